// File: rtl/instr_packer_pkg.sv
// instr_packer_pkg: shared Y86-64 opcode constants and byte-format helpers
// for the instruction-memory writer (instr_packer) and its length calculator.
//
// Contents:
//   - icode constants HALT..POPQ as used by the fetch stage
//   - FILL_BYTE (pad value for unused memory) and ICODE_MAX (highest legal icode)
//   - instr_fields_t: the decoded fields of one instruction

package instr_packer_pkg;

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] CMOVXX = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    localparam logic [7:0] FILL_BYTE = 8'hCC;
    localparam logic [3:0] ICODE_MAX = 4'hB;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
    } instr_fields_t;

endpackage

// File: rtl/instr_len_calc.sv
// instr_len_calc: combinational encoded-length calculator for one Y86-64 instruction.
//
// Ports:
//   icode_i     in   4  instruction code
//   need_reg_o  out  1  instruction carries a {rA,rB} byte
//   need_valc_o out  1  instruction carries an 8-byte valC
//   len_o       out  4  total encoded length: 1, 2, 9 or 10
//
// Illegal icodes report length 1 with no optional bytes; callers reject them separately.

module instr_len_calc
    import instr_packer_pkg::*;
(
    input  logic [3:0] icode_i,
    output logic       need_reg_o,
    output logic       need_valc_o,
    output logic [3:0] len_o
);

    always_comb begin
        need_reg_o  = 1'b0;
        need_valc_o = 1'b0;
        case (icode_i)
            CMOVXX, OPQ, PUSHQ, POPQ: need_reg_o = 1'b1;
            IRMOVQ, RMMOVQ, MRMOVQ: begin
                need_reg_o  = 1'b1;
                need_valc_o = 1'b1;
            end
            JXX, CALL: need_valc_o = 1'b1;
            default: ;
        endcase
        len_o = 4'd1 + {3'b000, need_reg_o} + {need_valc_o, 3'b000};
    end

endmodule

// File: rtl/instr_packer.sv
// instr_packer: serializes decoded Y86-64 fields into instruction-memory byte writes,
// one byte per cycle, at an auto-incrementing write pointer.
// Layout: {icode,ifun}, optional {rA,rB}, optional 8-byte little-endian valC.
//
// Ports:
//   clk_i     in   1         clock
//   rst_i     in   1         synchronous active-high reset (wins over clear_i)
//   clear_i   in   1         synchronous clear: pointer to BASE_ADDR, emission aborted
//   valid_i   in   1         instruction fields valid
//   fill_i    in   1         (INSTR_PACKER_FILL_EN only) pad pc_o..MEM_SIZE-1 with FILL_BYTE
//   ready_o   out  1         packer can accept fields
//   icode_i, ifun_i, ra_i, rb_i  in 4 each; valc_i in 64: instruction fields
//   wr_en_o   out  1         byte write strobe
//   wr_addr_o out  ADDR_W    byte write address (holds while wr_en_o=0)
//   wr_data_o out  8         byte write data (holds while wr_en_o=0)
//   pc_o      out  ADDR_W+1  address of the next instruction
//   count_o   out  16        instructions fully written (wraps)
//   err_o     out  1         one-cycle pulse: instruction rejected
//
// Optional feature macro: INSTR_PACKER_FILL_EN (adds fill_i and the fill state).

module instr_packer
    import instr_packer_pkg::*;
#(
    parameter int unsigned MEM_SIZE  = 1024,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              valid_i,
`ifdef INSTR_PACKER_FILL_EN
    input  logic              fill_i,
`endif
    output logic              ready_o,
    input  logic [3:0]        icode_i,
    input  logic [3:0]        ifun_i,
    input  logic [3:0]        ra_i,
    input  logic [3:0]        rb_i,
    input  logic [63:0]       valc_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic [ADDR_W:0]   pc_o,
    output logic [15:0]       count_o,
    output logic              err_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StEmit = 2'd1;
`ifdef INSTR_PACKER_FILL_EN
    localparam logic [1:0] StFill = 2'd2;
`endif

    localparam logic [ADDR_W:0] MemSizeP = (ADDR_W + 1)'(MEM_SIZE);
    localparam logic [ADDR_W:0] BaseP    = (ADDR_W + 1)'(BASE_ADDR);

    logic [1:0]        state_q, state_d;
    instr_fields_t     fields_q, fields_d;
    logic              need_reg_q, need_reg_d;
    logic              need_valc_q, need_valc_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        idx_q, idx_d;
    logic [ADDR_W:0]   pc_q, pc_d;
    logic [15:0]       count_q, count_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [7:0]        last_data_q, last_data_d;
`ifdef INSTR_PACKER_FILL_EN
    logic [ADDR_W:0]   fill_ptr_q, fill_ptr_d;
`endif

    logic              need_reg_in, need_valc_in;
    logic [3:0]        len_in;
    logic              reject;
    logic [2:0]        valc_sel;
    logic [7:0]        emit_byte;
    logic [ADDR_W-1:0] emit_addr;

    instr_len_calc u_len_calc (
        .icode_i     (icode_i),
        .need_reg_o  (need_reg_in),
        .need_valc_o (need_valc_in),
        .len_o       (len_in)
    );

    // Bounds check is done in ADDR_W+1 bits so pc_o == MEM_SIZE is representable.
    assign reject = (icode_i > ICODE_MAX) ||
                    ((pc_q + {{(ADDR_W - 3){1'b0}}, len_in}) > MemSizeP);

    // valC byte number; modulo-8 arithmetic covers both the 9- and 10-byte forms.
    assign valc_sel  = idx_q[2:0] - 3'd1 - {2'b00, need_reg_q};
    assign emit_addr = pc_q[ADDR_W-1:0] + {{(ADDR_W - 4){1'b0}}, idx_q};

    always_comb begin
        if (idx_q == 4'd0) begin
            emit_byte = {fields_q.icode, fields_q.ifun};
        end else if (need_reg_q && (idx_q == 4'd1)) begin
            emit_byte = {fields_q.ra, fields_q.rb};
        end else if (need_valc_q) begin
            emit_byte = fields_q.valc[{valc_sel, 3'b000} +: 8];
        end else begin
            emit_byte = 8'h00;
        end
    end

    // Write port: driven while emitting/filling, otherwise holds the last value.
    always_comb begin
        wr_en_o   = 1'b0;
        wr_addr_o = last_addr_q;
        wr_data_o = last_data_q;
        case (state_q)
            StEmit: begin
                wr_en_o   = 1'b1;
                wr_addr_o = emit_addr;
                wr_data_o = emit_byte;
            end
`ifdef INSTR_PACKER_FILL_EN
            StFill: begin
                wr_en_o   = 1'b1;
                wr_addr_o = fill_ptr_q[ADDR_W-1:0];
                wr_data_o = FILL_BYTE;
            end
`endif
            default: ;
        endcase
    end

    assign last_addr_d = wr_addr_o;
    assign last_data_d = wr_data_o;

    assign ready_o = (state_q == StIdle);
    assign pc_o    = pc_q;
    assign count_o = count_q;
    assign err_o   = err_q;

    always_comb begin
        state_d     = state_q;
        fields_d    = fields_q;
        need_reg_d  = need_reg_q;
        need_valc_d = need_valc_q;
        len_d       = len_q;
        idx_d       = idx_q;
        pc_d        = pc_q;
        count_d     = count_q;
        err_d       = 1'b0;
`ifdef INSTR_PACKER_FILL_EN
        fill_ptr_d  = fill_ptr_q;
`endif
        if (clear_i) begin
            state_d = StIdle;
            idx_d   = 4'd0;
            pc_d    = BaseP;
            count_d = 16'd0;
        end else begin
            case (state_q)
                StIdle: begin
`ifdef INSTR_PACKER_FILL_EN
                    if (fill_i) begin
                        if (pc_q < MemSizeP) begin
                            state_d    = StFill;
                            fill_ptr_d = pc_q;
                        end
                    end else
`endif
                    if (valid_i) begin
                        if (reject) begin
                            err_d = 1'b1;
                        end else begin
                            state_d     = StEmit;
                            fields_d    = '{icode: icode_i, ifun: ifun_i, ra: ra_i,
                                            rb: rb_i, valc: valc_i};
                            need_reg_d  = need_reg_in;
                            need_valc_d = need_valc_in;
                            len_d       = len_in;
                            idx_d       = 4'd0;
                        end
                    end
                end
                StEmit: begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == (len_q - 4'd1)) begin
                        state_d = StIdle;
                        idx_d   = 4'd0;
                        pc_d    = pc_q + {{(ADDR_W - 3){1'b0}}, len_q};
                        count_d = count_q + 16'd1;
                    end
                end
`ifdef INSTR_PACKER_FILL_EN
                StFill: begin
                    fill_ptr_d = fill_ptr_q + 1'b1;
                    if (fill_ptr_q == (MemSizeP - 1'b1)) begin
                        state_d = StIdle;
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            fields_q    <= '0;
            need_reg_q  <= 1'b0;
            need_valc_q <= 1'b0;
            len_q       <= 4'd0;
            idx_q       <= 4'd0;
            pc_q        <= BaseP;
            count_q     <= 16'd0;
            err_q       <= 1'b0;
            last_addr_q <= '0;
            last_data_q <= 8'h00;
`ifdef INSTR_PACKER_FILL_EN
            fill_ptr_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            fields_q    <= fields_d;
            need_reg_q  <= need_reg_d;
            need_valc_q <= need_valc_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            err_q       <= err_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
`ifdef INSTR_PACKER_FILL_EN
            fill_ptr_q  <= fill_ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_packer.sv
// tb_instr_packer: directed self-checking bench for instr_packer.
// Expected byte writes are queued when an instruction is driven and popped by a
// monitor on every wr_en_o cycle.

module tb_instr_packer;

    logic        clk = 1'b0;
    logic        rst_i, clear_i, valid_i;
    logic        fill_i;
    logic        ready_o, wr_en_o, err_o;
    logic [3:0]  icode_i, ifun_i, ra_i, rb_i;
    logic [63:0] valc_i;
    logic [9:0]  wr_addr_o;
    logic [7:0]  wr_data_o;
    logic [10:0] pc_o;
    logic [15:0] count_o;

    int checks = 0;
    int errors = 0;
    logic [17:0] sb[$];
    int m_pc = 0;
    int m_count = 0;

    always #5 clk = ~clk;

    instr_packer #(
        .MEM_SIZE  (1024),
        .ADDR_W    (10),
        .BASE_ADDR (0)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .clear_i   (clear_i),
        .valid_i   (valid_i),
`ifdef INSTR_PACKER_FILL_EN
        .fill_i    (fill_i),
`endif
        .ready_o   (ready_o),
        .icode_i   (icode_i),
        .ifun_i    (ifun_i),
        .ra_i      (ra_i),
        .rb_i      (rb_i),
        .valc_i    (valc_i),
        .wr_en_o   (wr_en_o),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o),
        .pc_o      (pc_o),
        .count_o   (count_o),
        .err_o     (err_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit f_need_reg(input logic [3:0] ic);
        return ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    endfunction

    function automatic bit f_need_valc(input logic [3:0] ic);
        return ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    endfunction

    // Queue the expected bytes of an instruction at m_pc; returns its length.
    task automatic push_bytes(input logic [3:0] ic, fn, a, b, input logic [63:0] vc,
                              input int max_bytes, output int len);
        logic [7:0] bytes[10];
        int n = 0;
        bytes[n++] = {ic, fn};
        if (f_need_reg(ic)) bytes[n++] = {a, b};
        if (f_need_valc(ic)) for (int k = 0; k < 8; k++) bytes[n++] = vc[8*k +: 8];
        len = n;
        for (int i = 0; i < n && i < max_bytes; i++) sb.push_back({10'(m_pc + i), bytes[i]});
    endtask

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_i === 1'b0 && wr_en_o === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 64'(wr_en_o), 64'd0);
            end else begin
                check("write", 64'({wr_addr_o, wr_data_o}), 64'(sb.pop_front()));
            end
        end
    end

    task automatic send(input logic [3:0] ic, fn, a, b, input logic [63:0] vc);
        int len;
        int lowcnt;
        bit rej;
        len = 1 + int'(f_need_reg(ic)) + 8 * int'(f_need_valc(ic));
        rej = (ic > 4'hB) || (m_pc + len > 1024);
        if (!rej) push_bytes(ic, fn, a, b, vc, 10, len);
        @(negedge clk);
        valid_i = 1'b1; icode_i = ic; ifun_i = fn; ra_i = a; rb_i = b; valc_i = vc;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        if (rej) begin
            check("err_pulse", 64'(err_o), 64'd1);
            check("rej_ready", 64'(ready_o), 64'd1);
            @(posedge clk);
            #1;
            check("err_one_cycle", 64'(err_o), 64'd0);
        end else begin
            check("acc_no_err", 64'(err_o), 64'd0);
            lowcnt = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (ready_o === 1'b1) break;
                lowcnt++;
            end
            check("emit_cycles", 64'(lowcnt), 64'(len));
            m_pc += len;
            m_count++;
        end
        check("pc", 64'(pc_o), 64'(m_pc));
        check("count", 64'(count_o), 64'(m_count));
    endtask

    initial begin
        int len;
        rst_i = 1'b1; clear_i = 1'b0; valid_i = 1'b0; fill_i = 1'b0;
        icode_i = '0; ifun_i = '0; ra_i = '0; rb_i = '0; valc_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_wr_en", 64'(wr_en_o), 64'd0);
        check("rst_wr_addr", 64'(wr_addr_o), 64'd0);
        check("rst_wr_data", 64'(wr_data_o), 64'd0);
        check("rst_pc", 64'(pc_o), 64'd0);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);

        // irmovq, halt, nop, rrmovq, jmp
        send(4'h3, 4'h0, 4'hF, 4'h8, 64'h8);
        send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0);
        send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
        send(4'h2, 4'h0, 4'h1, 4'h3, 64'h0);
        send(4'h7, 4'h0, 4'h5, 4'h5, 64'h100);
        check("hold_addr", 64'(wr_addr_o), 64'd22);
        check("hold_data", 64'(wr_data_o), 64'd0);

        // illegal icode
        send(4'hC, 4'h0, 4'h1, 4'h2, 64'h0);

        // rmmovq aborted by clear_i on its 4th byte, with valid_i raised at the same time
        push_bytes(4'h4, 4'h0, 4'h1, 4'h2, 64'h1122334455667788, 4, len);
        @(negedge clk);
        valid_i = 1'b1; icode_i = 4'h4; ifun_i = 4'h0; ra_i = 4'h1; rb_i = 4'h2;
        valc_i = 64'h1122334455667788;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (4) @(negedge clk);
        clear_i = 1'b1; valid_i = 1'b1; icode_i = 4'h1;
        @(posedge clk);
        #1;
        clear_i = 1'b0; valid_i = 1'b0;
        m_pc = 0; m_count = 0;
        check("clr_wr_en", 64'(wr_en_o), 64'd0);
        check("clr_pc", 64'(pc_o), 64'd0);
        check("clr_count", 64'(count_o), 64'd0);
        check("clr_ready", 64'(ready_o), 64'd1);
        check("clr_hold_addr", 64'(wr_addr_o), 64'd26);
        check("clr_hold_data", 64'(wr_data_o), 64'h77);
        @(negedge clk);
        check("clr_still_ready", 64'(ready_o), 64'd1);

        // clear_i with valid_i in IDLE: fields dropped
        clear_i = 1'b1; valid_i = 1'b1; icode_i = 4'h1;
        @(posedge clk);
        #1;
        clear_i = 1'b0; valid_i = 1'b0;
        @(negedge clk);
        check("clrv_ready", 64'(ready_o), 64'd1);
        check("clrv_pc", 64'(pc_o), 64'd0);
        check("clrv_count", 64'(count_o), 64'd0);

        // fill memory to pc 1020 with irmovq
        for (int i = 0; i < 102; i++) begin
            send(4'h3, 4'h0, 4'(i % 15), 4'h8, {$urandom, $urandom});
        end

        // irmovq no longer fits
        send(4'h3, 4'h0, 4'hF, 4'h1, 64'h55);

`ifdef INSTR_PACKER_FILL_EN
        begin
            int lowcnt;
            for (int a = 1020; a < 1024; a++) sb.push_back({10'(a), 8'hCC});
            @(negedge clk);
            fill_i = 1'b1; valid_i = 1'b1; icode_i = 4'h1;
            @(posedge clk);
            #1;
            fill_i = 1'b0; valid_i = 1'b0;
            lowcnt = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (ready_o === 1'b1) break;
                lowcnt++;
            end
            check("fill_cycles", 64'(lowcnt), 64'd4);
            check("fill_pc", 64'(pc_o), 64'd1020);
            check("fill_count", 64'(count_o), 64'(m_count));
        end
`endif

        send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
        send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
        send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
        send(4'h3, 4'h0, 4'hF, 4'h2, 64'h1);   // rejected at 1023
        send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);   // last byte at 1023, pc 1024
        send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);   // rejected: memory full
        send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0);   // rejected: memory full

`ifdef INSTR_PACKER_FILL_EN
        @(negedge clk);
        fill_i = 1'b1;
        @(posedge clk);
        #1;
        fill_i = 1'b0;
        check("fill_full_ready", 64'(ready_o), 64'd1);
        check("fill_full_pc", 64'(pc_o), 64'd1024);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
